mem_port_arbiter: RTL and testbench

//   Shares the single-port unified memory between the instruction-fetch port and the

---
 rtl/arb_pkg.sv | 32 +++
 rtl/arb_starve_counter.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the memory port arbiter.
//   - arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> ACK)
//   - grant_t     : which requester owns the current transaction
//   - lat_cnt_w() : width of the read-latency wait counter for a given MEM_LAT
//   - LAT_CNT_W   : counter width for the default MEM_LAT of 2
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Wait counter must hold MEM_LAT-1; $clog2(MEM_LAT+1) leaves headroom and
  // never collapses to a zero-width vector.
  function automatic int lat_cnt_w(input int mem_lat);
    return (mem_lat < 1) ? 1 : $clog2(mem_lat + 1);
  endfunction

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int LAT_CNT_W       = $clog2(MEM_LAT_DEFAULT + 1);

endpackage

// File: rtl/arb_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
//   Saturating count of consecutive load/store grants made while a fetch
//   was waiting. The parent uses at_max to force a fetch grant.
//   Ports:
//     clock  in  1  posedge clock
//     reset  in  1  synchronous, active-low
//     inc    in  1  a D grant was made while i_req was pending
//     clr    in  1  an I grant was made (clr wins over inc)
//     at_max out 1  count has reached STARVE_MAX
// ---------------------------------------------------------------------------
module arb_starve_counter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear on a fetch grant, otherwise count up and stick at max.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between the fetch port (I) and the
//   load/store port (D). One transaction at a time: grant in IDLE, strobe
//   the memory in ISSUE, wait out the read latency in WAIT, then pulse the
//   owner's ack with registered data in ACK. D wins ties unless the fetch
//   port has been passed over STARVE_MAX times in a row.
//   Ports:
//     clock, reset              posedge clock, synchronous active-low reset
//     i_req/i_addr              fetch request (held until i_ack)
//     i_rdata/i_ack             fetched word, one-cycle completion pulse
//     d_req/d_we/d_addr/d_wdata load/store request (held until d_ack)
//     d_rdata/d_ack             load data (0 for stores), completion pulse
//     mem_en/mem_we             memory strobe (1 cycle) and write enable
//     mem_addr/mem_wdata        latched address and store data
//     mem_rdata                 memory read data, MEM_LAT after mem_en
//     busy                      high whenever the FSM is not in IDLE
//   All outputs are registered.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int                   CNT_W    = lat_cnt_w(MEM_LAT);
  localparam logic [CNT_W-1:0]     LAT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]     LAT_ONE  = CNT_W'(1);

  arb_state_t        state_d,     state_q;
  grant_t            grant_d,     grant_q;
  logic              we_d,        we_q;
  logic [CNT_W-1:0]  wait_cnt_d,  wait_cnt_q;
  logic [DATA_W-1:0] i_rdata_d,   i_rdata_q;
  logic              i_ack_d,     i_ack_q;
  logic [DATA_W-1:0] d_rdata_d,   d_rdata_q;
  logic              d_ack_d,     d_ack_q;
  logic              mem_en_d,    mem_en_q;
  logic              mem_we_d,    mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d,  mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              busy_d,      busy_q;

  logic   capture;
  logic   starve_inc;
  logic   starve_clr;
  logic   starve_at_max;
  grant_t grant_sel;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clock  (clock),
    .reset  (reset),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

  // Next-state and next-output logic. Strobes (mem_en, mem_we, acks) default
  // low so they last exactly one cycle; everything else holds. capture marks
  // the edge on which mem_rdata is valid and gets steered to the owner.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    wait_cnt_d  = wait_cnt_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    capture     = 1'b0;
    starve_inc  = 1'b0;
    starve_clr  = 1'b0;
    grant_sel   = GNT_I;

    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          // D has priority except when the fetch port has been starved.
          grant_sel = (d_req && !(i_req && starve_at_max)) ? GNT_D : GNT_I;
          grant_d   = grant_sel;
          mem_en_d  = 1'b1;
          state_d   = ISSUE;
          if (grant_sel == GNT_D) begin
            we_d        = d_we;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            starve_inc  = i_req;
          end else begin
            we_d        = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            starve_clr  = 1'b1;
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = LAT_LOAD;
        // A one-cycle memory has its data ready right after the strobe.
        if (MEM_LAT <= 1) begin
          capture = 1'b1;
          state_d = ACK;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - LAT_ONE;
        if (wait_cnt_q <= LAT_ONE) begin
          wait_cnt_d = '0;
          capture    = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        i_rdata_d = '0;
        d_rdata_d = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Steer the returned word to whichever port owns this transaction.
    if (capture) begin
      if (grant_q == GNT_D) begin
        d_ack_d   = 1'b1;
        d_rdata_d = we_q ? '0 : mem_rdata;
      end else begin
        i_ack_d   = 1'b1;
        i_rdata_d = mem_rdata;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_I;
      we_q        <= 1'b0;
      wait_cnt_q  <= '0;
      i_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      wait_cnt_q  <= wait_cnt_d;
      i_rdata_q   <= i_rdata_d;
      i_ack_q     <= i_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_ack_q     <= d_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a transaction-timeline model.
//   Cycle N is the clock period in which the counter cyc equals N.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 2048;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [63:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
  logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_ack, d_ack, mem_en, mem_we, busy;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Free-running clock and cycle counter.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Bench memory contents: a fixed pattern, with 0xDEAD planted at 0x40.
  function automatic logic [63:0] memval(input logic [63:0] a);
    if (a == 64'h40) return 64'hDEAD;
    return a ^ 64'hA5A5_0000_0000_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [63:0] ia,
                               input logic dr, input logic dw,
                               input logic [63:0] da, input logic [63:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Waits for an ack on one port, then returns #1 into the following cycle.
  task automatic wait_ack(input bit port_d, input int budget, output int ack_cyc);
    bit seen;
    seen = 1'b0;
    ack_cyc = -1;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clock);
      if ((port_d ? d_ack : i_ack) === 1'b1) begin
        seen = 1'b1;
        ack_cyc = cyc;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL %s_ack_timeout: got no ack, required one within %0d cycles",
               port_d ? "d" : "i", budget);
    end
    @(posedge clock);
    #1;
  endtask

  // Memory: after a strobe in cycle k, data is presented in cycles k+MEM_LAT-1
  // and k+MEM_LAT; any other cycle carries a poison word.
  bit          rd_valid [DEPTH];
  logic [63:0] rd_val   [DEPTH];
  always @(posedge clock) begin
    if (mem_en === 1'b1 && cyc + MEM_LAT < DEPTH) begin
      for (int k = cyc + MEM_LAT - 1; k <= cyc + MEM_LAT; k++) begin
        rd_valid[k] = 1'b1;
        rd_val[k]   = memval(mem_addr);
      end
    end
    #1;
    mem_rdata = (cyc < DEPTH && rd_valid[cyc]) ? rd_val[cyc] : 64'h0BAD_0BAD_0BAD_0BAD;
  end

  // Model: a timeline of expected outputs. A grant decided at the end of
  // cycle c occupies cycles c+1 .. c+1+MEM_LAT and frees the port at c+2+MEM_LAT.
  bit          exp_busy [DEPTH];
  bit          exp_en   [DEPTH];
  bit          exp_we   [DEPTH];
  bit          exp_iack [DEPTH];
  bit          exp_dack [DEPTH];
  logic [63:0] exp_addr [DEPTH];
  logic [63:0] exp_wdat [DEPTH];
  logic [63:0] exp_rdat [DEPTH];
  int next_free = 0;
  int starve = 0;
  bit grant_log [$];

  always @(posedge clock) begin : model_proc
    int c;
    bit gd;
    logic [63:0] a;
    c = cyc;
    if (reset === 1'b0) begin
      for (int k = c + 1; k < c + MEM_LAT + 4 && k < DEPTH; k++) begin
        exp_busy[k] = 0; exp_en[k] = 0; exp_we[k] = 0;
        exp_iack[k] = 0; exp_dack[k] = 0;
      end
      next_free = c + 1;
      starve = 0;
    end else if (c >= next_free && (i_req || d_req) && c + MEM_LAT + 2 < DEPTH) begin
      gd = d_req && !(i_req && starve == STARVE_MAX);
      a  = gd ? d_addr : i_addr;
      for (int k = c + 1; k <= c + 1 + MEM_LAT; k++) exp_busy[k] = 1;
      exp_en[c+1]   = 1;
      exp_we[c+1]   = gd && d_we;
      exp_addr[c+1] = a;
      exp_wdat[c+1] = d_wdata;
      if (gd) exp_dack[c+1+MEM_LAT] = 1;
      else    exp_iack[c+1+MEM_LAT] = 1;
      exp_rdat[c+1+MEM_LAT] = (gd && d_we) ? 64'h0 : memval(a);
      if (gd && i_req) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      if (!gd) starve = 0;
      next_free = c + 2 + MEM_LAT;
      grant_log.push_back(gd);
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clock) begin
    if (cyc >= 1 && cyc < DEPTH) begin
      checkOutput($sformatf("busy@%0d", cyc), busy, exp_busy[cyc]);
      checkOutput($sformatf("mem_en@%0d", cyc), mem_en, exp_en[cyc]);
      checkOutput($sformatf("i_ack@%0d", cyc), i_ack, exp_iack[cyc]);
      checkOutput($sformatf("d_ack@%0d", cyc), d_ack, exp_dack[cyc]);
      if (exp_en[cyc]) begin
        checkOutput($sformatf("mem_we@%0d", cyc), mem_we, exp_we[cyc]);
        checkOutput($sformatf("mem_addr@%0d", cyc), mem_addr, exp_addr[cyc]);
        if (exp_we[cyc])
          checkOutput($sformatf("mem_wdata@%0d", cyc), mem_wdata, exp_wdat[cyc]);
      end
      if (exp_iack[cyc]) checkOutput($sformatf("i_rdata@%0d", cyc), i_rdata, exp_rdat[cyc]);
      if (exp_dack[cyc]) checkOutput($sformatf("d_rdata@%0d", cyc), d_rdata, exp_rdat[cyc]);
    end
  end

  // DUT-side logs of strobes and ack order (1 = D, 0 = I).
  int en_log [$];
  bit ack_log [$];
  always @(negedge clock) begin
    if (mem_en === 1'b1) en_log.push_back(cyc);
    if (d_ack === 1'b1) ack_log.push_back(1'b1);
    if (i_ack === 1'b1) ack_log.push_back(1'b0);
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, ack_c, d_c, i_c, s0, en_cnt, iack_cnt;
    bit done;
    bit exp_g [5];
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state.
    goto_cycle(2);
    @(negedge clock);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_acks", {i_ack, d_ack}, 0);
    checkOutput("rst_rdata", i_rdata | d_rdata, 0);
    goto_cycle(5);
    reset = 1'b1;

    // 1: single fetch at cycle 10.
    goto_cycle(10);
    applyStimulus(1, 64'h40, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("t1_mem_en_c11", mem_en, 1);
    checkOutput("t1_mem_addr_c11", mem_addr, 64'h40);
    @(negedge clock);
    @(negedge clock);
    checkOutput("t1_i_ack_c13", i_ack, 1);
    checkOutput("t1_i_rdata_c13", i_rdata, 64'hDEAD);
    goto_cycle(14);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    checkOutput("t1_busy_c14", busy, 0);

    // 2: simultaneous requests, D first, then I.
    goto_cycle(cyc + 1);
    s0 = en_log.size();
    applyStimulus(1, 64'h300, 1, 0, 64'h100, 0);
    wait_ack(1, 12, d_c);
    applyStimulus(1, 64'h300, 0, 0, 0, 0);
    wait_ack(0, 12, i_c);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_ack_spacing", i_c - d_c, MEM_LAT + 2);
    checkOutput("t2_en_count", en_log.size() - s0, 2);
    if (en_log.size() >= s0 + 2)
      checkOutput("t2_en_gap", en_log[s0+1] - en_log[s0], MEM_LAT + 2);

    // 3: starvation relief, D,D,D,D,I.
    goto_cycle(cyc + 1);
    grant_log.delete();
    ack_log.delete();
    applyStimulus(1, 64'h500, 1, 0, 64'h600, 0);
    wait_ack(0, 40, ack_c);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t3_starve_cnt", u_dut.u_starve.cnt_q, 0);
    checkOutput("t3_model_grants", grant_log.size(), 5);
    checkOutput("t3_ack_count", ack_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size()) checkOutput($sformatf("t3_model_grant%0d", k), grant_log[k], exp_g[k]);
      if (k < ack_log.size())   checkOutput($sformatf("t3_ack%0d", k), ack_log[k], exp_g[k]);
    end

    // 4: store.
    goto_cycle(cyc + 1);
    en_cnt = 0; iack_cnt = 0; done = 0;
    applyStimulus(0, 0, 1, 1, 64'h8, 64'h1234);
    for (int n = 0; n < 12 && !done; n++) begin
      @(negedge clock);
      if (i_ack === 1'b1) iack_cnt++;
      if (mem_en === 1'b1) begin
        en_cnt++;
        checkOutput("t4_mem_we", mem_we, 1);
        checkOutput("t4_mem_addr", mem_addr, 64'h8);
        checkOutput("t4_mem_wdata", mem_wdata, 64'h1234);
      end
      if (d_ack === 1'b1) begin
        done = 1;
        checkOutput("t4_d_rdata", d_rdata, 0);
      end
    end
    checkOutput("t4_d_ack_seen", done, 1);
    @(posedge clock);
    #1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    if (i_ack === 1'b1) iack_cnt++;
    checkOutput("t4_en_count", en_cnt, 1);
    checkOutput("t4_i_ack_count", iack_cnt, 0);

    // 5: reset during WAIT drops the fetch; held request restarts cleanly.
    goto_cycle(cyc + 1);
    t = cyc;
    applyStimulus(1, 64'h200, 0, 0, 0, 0);
    goto_cycle(t + 2);
    reset = 1'b0;
    goto_cycle(t + 3);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_mem_en", mem_en, 0);
    checkOutput("t5_acks", {i_ack, d_ack}, 0);
    checkOutput("t5_mem_addr", mem_addr, 0);
    checkOutput("t5_rdata", i_rdata | d_rdata, 0);
    wait_ack(0, 10, ack_c);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5_ack_cycle", ack_c, t + 3 + 1 + MEM_LAT);

    // 6: fetch request dropped in ISSUE still completes exactly once.
    goto_cycle(cyc + 1);
    t = cyc;
    en_cnt = 0; iack_cnt = 0;
    applyStimulus(1, 64'h700, 0, 0, 0, 0);
    goto_cycle(t + 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (mem_en === 1'b1) en_cnt++;
      if (i_ack === 1'b1) iack_cnt++;
    end
    checkOutput("t6_i_ack_count", iack_cnt, 1);
    checkOutput("t6_en_count", en_cnt, 1);

    goto_cycle(cyc + 3);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
